mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, 64: number of 32-bit words stored; power of two, 4..1024.
REQ-002 Parameter WAIT_CYCLES, 2: wait states inserted before each response; 0..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 MemRd  input  1  read request from the multicycle control unit; held high until MemReady is seen.
REQ-006 MemWrite  input  1  write request from the multicycle control unit; held high until MemReady is seen.
REQ-007 Addr  input  32  byte address, sampled at request acceptance.
REQ-008 WriteData  input  32  store data, sampled at request acceptance.
REQ-009 ReadData  output  32  registered read data.
REQ-010 MemReady  output  1  one-cycle completion pulse.
REQ-011 Busy  output  1  high while a request is in progress (states BUSY and DONE).
REQ-012 AddrErr  output  1  one-cycle pulse: misaligned access rejected.
REQ-013 ProtErr  output  1  one-cycle pulse: MemRd and MemWrite both high.

Function
REQ-014 FSM states: IDLE, BUSY and DONE; all outputs SHALL be registered.
REQ-015 In IDLE, exactly one of MemRd/MemWrite high with Addr[1:0]==0: latch Addr, WriteData and op, load the wait counter with WAIT_CYCLES, then go to BUSY (WAIT_CYCLES>0) or DONE (WAIT_CYCLES==0).
REQ-016 In BUSY: decrement the counter each cycle; go to DONE at the edge where the counter equals 1.
REQ-017 In DONE: MemReady=1 for exactly one cycle; unconditional return to IDLE.
REQ-018 Latency: MemReady SHALL be high in cycle WAIT_CYCLES+1 after the accepting edge.
REQ-019 Word index SHALL be Addr[log2(DEPTH)+1:2]; upper address bits ignored (aliasing, no error).
REQ-020 Write: array word updated at the edge entering DONE; ReadData unchanged.
REQ-021 Read: ReadData loaded at the edge entering DONE; held until the next completed read.
REQ-022 Requests changing during BUSY/DONE SHALL be ignored; latched values govern the access.
REQ-023 Requester drops its request the cycle after MemReady; a request still high in IDLE after DONE SHALL be accepted as a new request.
REQ-024 Both MemRd and MemWrite high in IDLE: ProtErr pulses 1 cycle, no access, FSM stays IDLE; repeats each cycle while the condition persists.
REQ-025 Misaligned request (Addr[1:0]!=0) in IDLE: AddrErr pulses 1 cycle, no access, no MemReady, FSM stays IDLE; ProtErr takes precedence if both apply.
REQ-026 Read after write to the same word SHALL return the written data.

Reset
REQ-027 rst high SHALL force state IDLE, counter 0, MemReady 0, Busy 0, AddrErr 0, ProtErr 0, ReadData 0 asynchronously.
REQ-028 Array contents SHALL NOT be reset.
REQ-029 Reset during BUSY/DONE SHALL abort the access: no write committed, no MemReady.
REQ-030 First request SHALL be accepted at the first rising edge with rst low.

Verification
REQ-031 WAIT_CYCLES=2: write 0xDEADBEEF to Addr 0x10, then read Addr 0x10 -> MemReady in cycle 3 after each acceptance; ReadData=0xDEADBEEF.
REQ-032 WAIT_CYCLES=0: read of a word previously written with 0x12345678 -> MemReady in the cycle after acceptance, ReadData=0x12345678.
REQ-033 Addr=0x13 with MemRd -> AddrErr one cycle; no MemReady; ReadData unchanged; Busy stays 0.
REQ-034 MemRd=MemWrite=1 for 2 cycles -> ProtErr high for 2 cycles; array unchanged; FSM stays IDLE.
REQ-035 Write 0xAAAA5555 to word 3; assert rst in BUSY; then read word 3 -> old value returned; no MemReady during the aborted access.
REQ-036 DEPTH=64: write 0x1 to Addr 0x100, then read Addr 0x000 -> 0x1 (aliasing); Addr changed mid-BUSY -> latched address used.

Source files
------------

// File: rtl/mem_responder.sv
// Multicycle-CPU memory responder: word-addressed array that answers a held
// MemRd/MemWrite request after WAIT_CYCLES wait states, flagging bad requests.
module mem_responder #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRd,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        Busy,
    output logic        AddrErr,
    output logic        ProtErr
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            wr_q, wr_d;
    logic [31:0]     rdata_q;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            aerr_q, aerr_d;
    logic            perr_q, perr_d;
    logic            commit;

    logic [31:0]     mem_q [DEPTH];

    // Address bits above the word index alias onto the same words by design.
    logic            unused_addr;
    assign unused_addr = ^Addr[31:AW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        perr_d  = 1'b0;
        aerr_d  = 1'b0;
        commit  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (MemRd && MemWrite) begin
                    perr_d = 1'b1;
                end else if (MemRd || MemWrite) begin
                    if (Addr[1:0] != 2'b00) begin
                        aerr_d = 1'b1;
                    end else begin
                        idx_d   = Addr[AW+1:2];
                        wdata_d = WriteData;
                        wr_d    = MemWrite;
                        cnt_d   = 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            // Zero wait states: the accepting edge is also the access edge.
                            state_d = S_DONE;
                            commit  = 1'b1;
                        end else begin
                            state_d = S_BUSY;
                        end
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                    commit  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = commit;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            aerr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            aerr_q  <= aerr_d;
            perr_q  <= perr_d;
            if (commit && !wr_d) begin
                rdata_q <= mem_q[idx_d];
            end
        end
    end

    // Storage is not reset; the rst gate keeps an edge under reset from committing.
    always_ff @(posedge clk) begin
        if (commit && wr_d && !rst) begin
            mem_q[idx_d] <= wdata_d;
        end
    end

    assign ReadData = rdata_q;
    assign MemReady = ready_q;
    assign Busy     = busy_q;
    assign AddrErr  = aerr_q;
    assign ProtErr  = perr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench: two responders (2 and 0 wait states) checked
// against an array model indexed by (addr/4) mod DEPTH.
module tb_mem_responder;

    localparam int unsigned DEP0 = 64;
    localparam int unsigned DEP1 = 16;

    logic        clk = 1'b0;
    logic        rst_s  [2];
    logic        rd_s   [2];
    logic        wr_s   [2];
    logic [31:0] addr_s [2];
    logic [31:0] wd_s   [2];
    logic [31:0] rdat_s [2];
    logic        rdy_s  [2];
    logic        busy_s [2];
    logic        aerr_s [2];
    logic        perr_s [2];

    int unsigned wc  [2] = '{2, 0};
    int unsigned dep [2] = '{DEP0, DEP1};
    logic [31:0] model [2][64];
    logic [31:0] last_rd [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEP0), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst_s[0]), .MemRd(rd_s[0]), .MemWrite(wr_s[0]),
        .Addr(addr_s[0]), .WriteData(wd_s[0]), .ReadData(rdat_s[0]),
        .MemReady(rdy_s[0]), .Busy(busy_s[0]), .AddrErr(aerr_s[0]), .ProtErr(perr_s[0])
    );

    mem_responder #(.DEPTH(DEP1), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst_s[1]), .MemRd(rd_s[1]), .MemWrite(wr_s[1]),
        .Addr(addr_s[1]), .WriteData(wd_s[1]), .ReadData(rdat_s[1]),
        .MemReady(rdy_s[1]), .Busy(busy_s[1]), .AddrErr(aerr_s[1]), .ProtErr(perr_s[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned widx(input int k, input logic [31:0] a);
        return (a / 4) % dep[k];
    endfunction

    // Called and returns at a negedge. Request is held until MemReady is seen.
    task automatic xfer(input int k, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble);
        int n;
        bit seen;
        rd_s[k]   = !wr;
        wr_s[k]   = wr;
        addr_s[k] = a;
        wd_s[k]   = d;
        n    = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (rdy_s[k]) begin
                seen = 1'b1;
            end else begin
                check("busy_wait", 32'(busy_s[k]), 32'd1);
                n++;
                if (scramble) begin
                    addr_s[k] = $urandom;
                    wd_s[k]   = $urandom;
                end
            end
        end
        check("ready_seen", 32'(seen), 32'd1);
        check("latency", 32'(n), 32'(wc[k]));
        check("busy_done", 32'(busy_s[k]), 32'd1);
        if (wr) begin
            model[k][widx(k, a)] = d;
            check("rdata_hold", rdat_s[k], last_rd[k]);
        end else begin
            last_rd[k] = model[k][widx(k, a)];
            check("rdata", rdat_s[k], last_rd[k]);
        end
        @(negedge clk);
        rd_s[k] = 1'b0;
        wr_s[k] = 1'b0;
        @(posedge clk);
        #1;
        check("ready_pulse", 32'(rdy_s[k]), 32'd0);
        check("busy_idle", 32'(busy_s[k]), 32'd0);
        @(negedge clk);
    endtask

    // Rejected request held for 'cycles' edges; only error pulses may appear.
    task automatic err_req(input int k, input bit rd, input bit wr,
                           input logic [31:0] a, input int cycles);
        bit pe;
        bit ae;
        rd_s[k]   = rd;
        wr_s[k]   = wr;
        addr_s[k] = a;
        wd_s[k]   = $urandom;
        pe = rd && wr;
        ae = !pe && (rd != wr) && (a[1:0] != 2'b00);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            check("proterr", 32'(perr_s[k]), 32'(pe));
            check("addrerr", 32'(aerr_s[k]), 32'(ae));
            check("err_noready", 32'(rdy_s[k]), 32'd0);
            check("err_nobusy", 32'(busy_s[k]), 32'd0);
            check("err_rdata", rdat_s[k], last_rd[k]);
        end
        @(negedge clk);
        rd_s[k] = 1'b0;
        wr_s[k] = 1'b0;
        @(posedge clk);
        #1;
        check("proterr_clr", 32'(perr_s[k]), 32'd0);
        check("addrerr_clr", 32'(aerr_s[k]), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          k;
        int unsigned r;
        logic [31:0] a;
        bit          op;

        for (int i = 0; i < 2; i++) begin
            rst_s[i]  = 1'b1;
            rd_s[i]   = 1'b0;
            wr_s[i]   = 1'b0;
            addr_s[i] = '0;
            wd_s[i]   = '0;
            last_rd[i] = '0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_rdata", rdat_s[i], 32'd0);
            check("rst_ready", 32'(rdy_s[i]), 32'd0);
            check("rst_busy", 32'(busy_s[i]), 32'd0);
            check("rst_aerr", 32'(aerr_s[i]), 32'd0);
            check("rst_perr", 32'(perr_s[i]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;

        for (int i = 0; i < 2; i++) begin
            for (int unsigned w = 0; w < dep[i]; w++) begin
                xfer(i, 1'b1, 32'(w * 4), $urandom, 1'b0);
            end
        end

        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        xfer(0, 1'b0, 32'h10, 32'h0, 1'b0);
        check("deadbeef", rdat_s[0], 32'hDEADBEEF);

        xfer(1, 1'b1, 32'h24, 32'h12345678, 1'b0);
        xfer(1, 1'b0, 32'h24, 32'h0, 1'b0);
        check("w0_read", rdat_s[1], 32'h12345678);

        err_req(0, 1'b1, 1'b0, 32'h13, 1);
        err_req(0, 1'b1, 1'b1, 32'h10, 2);
        err_req(0, 1'b1, 1'b1, 32'h11, 1);
        xfer(0, 1'b0, 32'h10, 32'h0, 1'b0);
        check("prot_unchanged", rdat_s[0], 32'hDEADBEEF);

        xfer(0, 1'b1, 32'h100, 32'h1, 1'b0);
        xfer(0, 1'b0, 32'h000, 32'h0, 1'b1);
        check("alias_read", rdat_s[0], 32'h1);

        // Reset in BUSY aborts a write to word 3.
        rd_s[0]   = 1'b0;
        wr_s[0]   = 1'b1;
        addr_s[0] = 32'hC;
        wd_s[0]   = 32'hAAAA5555;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy_s[0]), 32'd1);
        #2;
        rst_s[0] = 1'b1;
        #1;
        check("abort_ready", 32'(rdy_s[0]), 32'd0);
        check("abort_busy0", 32'(busy_s[0]), 32'd0);
        check("abort_rdata", rdat_s[0], 32'd0);
        last_rd[0] = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("abort_noready", 32'(rdy_s[0]), 32'd0);
        end
        @(negedge clk);
        wr_s[0]  = 1'b0;
        rst_s[0] = 1'b0;
        xfer(0, 1'b0, 32'hC, 32'h0, 1'b0);

        for (int t = 0; t < 300; t++) begin
            k  = int'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            a  = $urandom;
            op = 1'($urandom_range(0, 1));
            if (r == 0) begin
                err_req(k, 1'b1, 1'b1, a, int'($urandom_range(1, 3)));
            end else if (r == 1) begin
                a[1:0] = 2'($urandom_range(1, 3));
                err_req(k, op, !op, a, 1);
            end else begin
                a[1:0] = 2'b00;
                xfer(k, op, a, $urandom, 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
